// File: rtl/rsa_io_pkg.sv
// Shared RSA host-I/O types: transfer-state encoding and byte-count helpers.
package rsa_io_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_SEND = 2'd2
  } io_state_e;

  localparam int unsigned RSA_IO_N = 32;
  localparam int unsigned NBYTES   = RSA_IO_N / 8;

  function automatic int unsigned nbytes(input int unsigned n);
    return n / 8;
  endfunction

endpackage

// File: rtl/parallel_to_serial.sv
// Word-to-byte serializer, MSB first; P2S_LENGTH_HEADER_EN prepends a byte-count header.
// First byte valid the cycle after acceptance; tx_ready low stalls with tx_byte held.
module parallel_to_serial
  import rsa_io_pkg::*;
#(
  parameter int N     = 32,
  parameter int Nlog2 = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] in_word,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [7:0]   tx_byte,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic         busy,
  output logic         done
);

  localparam int NB_W = nbytes(N);
  localparam int CW   = (Nlog2 > 3) ? Nlog2 - 2 : 1;
  localparam logic [CW-1:0] LAST = CW'(NB_W - 1);

  io_state_e    state_q, state_d;
  logic [N-1:0] shift_q, shift_d, shift_nxt;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]   tx_byte_q, tx_byte_d;
  logic         tx_valid_q, tx_valid_d;
  logic         done_q, done_d;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    tx_byte_d  = tx_byte_q;
    tx_valid_d = tx_valid_q;
    done_d     = 1'b0;
    shift_nxt  = shift_q << 8;

    case (state_q)
      ST_IDLE: begin
        tx_valid_d = 1'b0;
        tx_byte_d  = 8'h00;
        if (in_valid) begin
          shift_d    = in_word;
          cnt_d      = '0;
          tx_valid_d = 1'b1;
`ifdef P2S_LENGTH_HEADER_EN
          state_d    = ST_HDR;
          tx_byte_d  = 8'(NB_W);
`else
          state_d    = ST_SEND;
          tx_byte_d  = in_word[N-1 -: 8];
`endif
        end
      end
`ifdef P2S_LENGTH_HEADER_EN
      ST_HDR: begin
        if (tx_ready) begin
          state_d   = ST_SEND;
          tx_byte_d = shift_q[N-1 -: 8];
        end
      end
`endif
      ST_SEND: begin
        if (tx_ready) begin
          shift_d = shift_nxt;
          if (cnt_q == LAST) begin
            state_d    = ST_IDLE;
            cnt_d      = '0;
            tx_valid_d = 1'b0;
            tx_byte_d  = 8'h00;
            done_d     = 1'b1;
          end else begin
            cnt_d     = cnt_q + 1'b1;
            tx_byte_d = shift_nxt[N-1 -: 8];
          end
        end
      end
      default: begin
        state_d    = ST_IDLE;
        tx_valid_d = 1'b0;
        tx_byte_d  = 8'h00;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      tx_byte_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      tx_byte_q  <= tx_byte_d;
      tx_valid_q <= tx_valid_d;
      done_q     <= done_d;
    end
  end

  assign tx_byte  = tx_byte_q;
  assign tx_valid = tx_valid_q;
  assign done     = done_q;
  assign busy     = (state_q != ST_IDLE);
  assign in_ready = (state_q == ST_IDLE);

endmodule

// File: tb/tb_parallel_to_serial.sv
// Bench for parallel_to_serial: queue-based byte model checked every cycle, plus literal sequences.
module tb_parallel_to_serial;

  localparam int N  = 32;
  localparam int NB = N / 8;
`ifdef P2S_LENGTH_HEADER_EN
  localparam int H = 1;
`else
  localparam int H = 0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] in_word;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   tx_byte;
  logic         tx_valid;
  logic         tx_ready;
  logic         busy;
  logic         done;

  parallel_to_serial #(.N(N), .Nlog2(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_word  (in_word),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .tx_byte  (tx_byte),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;
  int irdy_lo = 0;
  int done_cnt = 0;

  logic [7:0] exp_q[$];
  bit         done_exp = 1'b0;
  logic [7:0] log_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: an idle block loads the whole byte list on acceptance; one byte leaves per tx_ready.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_q.delete();
      done_exp = 1'b0;
    end else begin
      done_exp = 1'b0;
      if (exp_q.size() == 0) begin
        if (in_valid) begin
          if (H == 1) exp_q.push_back(8'(NB));
          for (int k = 0; k < NB; k++) exp_q.push_back(in_word[N-1-8*k -: 8]);
        end
      end else if (tx_ready) begin
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) done_exp = 1'b1;
      end
    end
  end

  always @(posedge clk)
    if (rst && tx_valid && tx_ready) log_q.push_back(tx_byte);

  always @(negedge clk) begin
    bit ev;
    if (chk_en) begin
      ev = (exp_q.size() != 0);
      chk("tx_valid", {31'b0, tx_valid}, {31'b0, ev});
      chk("busy", {31'b0, busy}, {31'b0, ev});
      chk("in_ready", {31'b0, in_ready}, {31'b0, !ev});
      chk("done", {31'b0, done}, {31'b0, done_exp});
      if (ev) chk("tx_byte", {24'b0, tx_byte}, {24'b0, exp_q[0]});
      if (!in_ready) irdy_lo++;
      if (done) done_cnt++;
    end
  end

  task automatic clear_stats();
    log_q.delete();
    irdy_lo = 0;
    done_cnt = 0;
  endtask

  task automatic expect_bytes(input string nm, input logic [79:0] e, input int n);
    chk({nm, "_len"}, log_q.size(), n);
    for (int i = 0; i < n; i++)
      if (i < log_q.size()) chk(nm, {24'b0, log_q[i]}, {24'b0, e[8*(n-1-i) +: 8]});
  endtask

  task automatic expect_word(input string nm, input logic [31:0] w);
`ifdef P2S_LENGTH_HEADER_EN
    expect_bytes(nm, {40'b0, 8'h04, w}, 5);
`else
    expect_bytes(nm, {48'b0, w}, 4);
`endif
  endtask

  task automatic offer(input logic [31:0] w);
    in_word  = w;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int k;
    rst = 1'b1; in_valid = 1'b0; in_word = '0; tx_ready = 1'b0;
    #1 rst = 1'b0;
    #1;
    chk("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
    chk("rst_tx_byte", {24'b0, tx_byte}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk_en = 1'b1;
    cycles(2);
    rst = 1'b1;
    cycles(1);

    // Basic serialization at full rate
    clear_stats();
    tx_ready = 1'b1;
    offer(32'hDEADBEEF);
    cycles(NB + H + 3);
    expect_word("basic", 32'hDEADBEEF);
    chk("basic_irdy_lo", irdy_lo, NB + H);
    chk("basic_done_cnt", done_cnt, 1);

    // Backpressure pattern 1,0,0,1
    clear_stats();
    in_word = 32'h01020304; in_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tx_ready = (i % 4 == 0) || (i % 4 == 3);
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    expect_word("bp", 32'h01020304);
    chk("bp_done_cnt", done_cnt, 1);

    // in_valid while busy is ignored
    clear_stats();
    tx_ready = 1'b1;
    offer(32'hAABBCCDD);
    cycles(1);
    in_word = 32'h11111111; in_valid = 1'b1;
    cycles(1);
    in_valid = 1'b0;
    cycles(NB + H + 3);
    expect_word("ignore", 32'hAABBCCDD);
    chk("ignore_done_cnt", done_cnt, 1);

    // Asynchronous reset after the second byte
    clear_stats();
    tx_ready = 1'b1;
    offer(32'h12345678);
    k = 0;
    while (log_q.size() < 2 + H && k < 20) begin
      cycles(1);
      k++;
    end
    chk("rst_wait_timeout", {31'b0, k < 20}, 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("arst_tx_valid", {31'b0, tx_valid}, 32'd0);
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_in_ready", {31'b0, in_ready}, 32'd1);
    cycles(2);
    rst = 1'b1;
    cycles(3);
    chk("arst_no_done", done_cnt, 0);
    clear_stats();
    offer(32'h9ABCDEF0);
    cycles(NB + H + 3);
    expect_word("after_rst", 32'h9ABCDEF0);
    chk("after_rst_done_cnt", done_cnt, 1);

    // Back-to-back: second word offered in the done cycle
    clear_stats();
    tx_ready = 1'b1;
    in_word = 32'h01234567; in_valid = 1'b1;
    cycles(1);
    in_word = 32'h89ABCDEF;
    k = 0;
    while (!done_exp && k < 20) begin
      cycles(1);
      k++;
    end
    chk("b2b_wait_timeout", {31'b0, k < 20}, 32'd1);
    cycles(1);
    in_valid = 1'b0;
    cycles(NB + H + 3);
`ifdef P2S_LENGTH_HEADER_EN
    expect_bytes("b2b", {8'h04, 32'h01234567, 8'h04, 32'h89ABCDEF}, 10);
`else
    expect_bytes("b2b", {16'b0, 32'h01234567, 32'h89ABCDEF}, 8);
`endif
    chk("b2b_done_cnt", done_cnt, 2);
    chk("b2b_irdy_lo", irdy_lo, 2 * (NB + H));

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      tx_ready = ($urandom_range(0, 3) != 0);
      in_valid = ($urandom_range(0, 2) == 0);
      in_word  = $urandom;
      cycles(1);
    end
    in_valid = 1'b0;
    tx_ready = 1'b1;
    cycles(NB + H + 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
